gpu_ram_scanner: RTL

//  GPU-side reader for the 1024x32 object/tile RAM shared with the Z80 (8-bit write side).
//  On a start pulse, sweeps a contiguous word range through the RAM's 32-bit read port.

---
 rtl/gpu_ram_scanner_pkg.sv | 15 +
 rtl/gpu_ram_scanner_if.sv | 27 ++
 rtl/gpu_ram_scanner_fifo.sv | 46 ++++
 rtl/gpu_ram_scanner.sv | 128 ++++++++++++
 4 files changed

// File: rtl/gpu_ram_scanner_pkg.sv
// Shared constants for the GPU-side RAM scanner: default widths, read latency, FSM encodings.
// Latency: n/a (declarations only). Backpressure: n/a.
// Imported by the interface and the scanner top.
package gpu_scan_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int RD_LATENCY     = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

endpackage

// File: rtl/gpu_ram_scanner_if.sv
// RAM read-port and output-stream bundle between the scanner and its neighbours.
// Latency: n/a (wiring only). Backpressure: out_ready stalls the stream.
// master = scanner side, slave = RAM/renderer side.
interface gpu_ram_scanner_if
    import gpu_scan_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              mem_rden;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_q;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;

    modport master (
        output mem_rden, mem_addr, out_valid, out_data, out_index,
        input  mem_q, out_ready
    );

    modport slave (
        input  mem_rden, mem_addr, out_valid, out_data, out_index,
        output mem_q, out_ready
    );
endinterface

// File: rtl/gpu_ram_scanner_fifo.sv
// Synchronous first-word-fall-through FIFO for {index,data} scan entries, with occupancy count.
// Latency: an entry pushed on an edge is visible at pop_dat_o right after that edge.
// Backpressure: none internally; the producer's credit scheme keeps it from overflowing.
module gpu_scan_fifo #(
    parameter int W     = 42,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [W-1:0]             push_dat_i,
    input  logic                     pop_i,
    output logic [W-1:0]             pop_dat_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   cnt_q;
    logic          pop_ok;

    assign empty_o   = (cnt_q == '0);
    assign pop_ok    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = cnt_q;

    // Storage is cleared on reset so the stream outputs read zero before the first push.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_ok);
        end
    end
endmodule

// File: rtl/gpu_ram_scanner.sv
// Sweeps a word range of the shared 1024x32 RAM on start and streams {data,offset}; optional GPU_SCAN_SKIP_EMPTY_EN drops zero words.
// Latency: first out_valid 3 clocks after start is sampled; 1 word/clock sustained with out_ready high.
// Backpressure: out_ready low holds the stream; reads stop once FIFO + in-flight reach FIFO_DEPTH.
module gpu_ram_scanner
    import gpu_scan_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    gpu_ram_scanner_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic              done_q, done_d;

    // Read-latency tags: one stage per clock of the RAM's registered read path.
    logic              t1_vld_q, t2_vld_q;
    logic [ADDR_W-1:0] t1_idx_q, t2_idx_q;

    logic              issue;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_cnt;
    logic [OW-1:0]     occ;
    logic [OW-1:0]     occ_after;

    assign occ       = OW'(fifo_cnt) + OW'(t1_vld_q) + OW'(t2_vld_q);
    assign issue     = (state_q == S_FETCH) && (occ < OW'(FIFO_DEPTH));
    assign occ_after = OW'(fifo_cnt) + OW'(push) - OW'(pop);

`ifdef GPU_SCAN_SKIP_EMPTY_EN
    assign push = t2_vld_q && (bus.mem_q != '0);
`else
    assign push = t2_vld_q;
`endif

    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_valid = !fifo_empty;
    assign bus.mem_rden  = issue;
    assign bus.mem_addr  = base_q + issued_q[ADDR_W-1:0];
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;

    gpu_scan_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_i     (push),
        .push_dat_i ({t2_idx_q, bus.mem_q}),
        .pop_i      (pop),
        .pop_dat_o  ({bus.out_index, bus.out_data}),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        count_d  = count_q;
        issued_d = issued_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    count_d  = count;
                    issued_d = '0;
                    if (count == '0) done_d  = 1'b1;
                    else             state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (issue) begin
                    issued_d = issued_q + (ADDR_W+1)'(1);
                    if (issued_d == count_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // done fires on the edge that empties the last stage; state leaves one clock later
                // so busy still covers the done cycle.
                if (done_q)                                done_d  = 1'b0;
                else if (!t1_vld_q && occ_after == '0)     done_d  = 1'b1;
                if (done_q)                                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            count_q  <= '0;
            issued_q <= '0;
            done_q   <= 1'b0;
            t1_vld_q <= 1'b0;
            t1_idx_q <= '0;
            t2_vld_q <= 1'b0;
            t2_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            done_q   <= done_d;
            t1_vld_q <= issue;
            t1_idx_q <= issued_q[ADDR_W-1:0];
            t2_vld_q <= t1_vld_q;
            t2_idx_q <= t1_idx_q;
        end
    end
endmodule
